// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch state encoding, fault codes and the default datapath width.
package cpu_defs;

  localparam int CPU_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts WAIT cycles without an ack; expired marks the last cycle before a timeout fault.
module fetch_timeout_ctr #(
  parameter  int TIMEOUT = 16,
  localparam int TO_W    = $clog2(TIMEOUT)
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + TO_W'(1);
  end

  assign expired = (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle-CPU fetch stage: PC -> imem req/ack -> IR, with PC increment pulse and sticky faults.
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] PC_in,
  input  logic              fetch_start,
  input  logic              flush,
  input  logic              fault_clr,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              pc_inc,
  output logic [DATA_W-1:0] IR_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              fetch_busy,
  output logic              FAULT,
  output logic [1:0]        fault_code
);

  fetch_state_e      state, state_n;
  logic              req_n, vld_n, inc_n, fault_n;
  logic [DATA_W-1:0] addr_n, ir_n;
  logic [1:0]        code_n;
  logic              launch, misaligned;
  logic              cnt_clr, cnt_en, cnt_expired;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_to_ctr (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  assign misaligned = (PC_in[1:0] != 2'b00);

  always_comb begin
    state_n = state;
    req_n   = imem_req;
    addr_n  = imem_addr;
    ir_n    = IR_out;
    vld_n   = ir_valid;
    inc_n   = 1'b0;
    fault_n = FAULT;
    code_n  = fault_code;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    // PC_in is stale during the pc_inc cycle, so HOLD only relaunches after it
    launch  = fetch_start &&
              (state == IDLE || (state == HOLD && ir_ready && !pc_inc));

    if (fault_clr) begin
      fault_n = 1'b0;
      code_n  = FLT_NONE;
    end

    if (flush) begin
      state_n = IDLE;
      req_n   = 1'b0;
      vld_n   = 1'b0;
      cnt_clr = 1'b0 | 1'b1;
    end else if (launch) begin
      vld_n = 1'b0;
      if (misaligned) begin
        fault_n = 1'b1;
        code_n  = FLT_MISALIGN;
        state_n = IDLE;
      end else begin
        addr_n  = PC_in;
        req_n   = 1'b1;
        cnt_clr = 1'b1;
        state_n = WAIT;
      end
    end else begin
      case (state)
        WAIT: begin
          if (imem_ack) begin
            ir_n    = imem_rdata;
            vld_n   = 1'b1;
            req_n   = 1'b0;
            inc_n   = 1'b1;
            cnt_clr = 1'b1;
            state_n = HOLD;
          end else if (cnt_expired) begin
            req_n   = 1'b0;
            fault_n = 1'b1;
            code_n  = FLT_TIMEOUT;
            cnt_clr = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            vld_n   = 1'b0;
            state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      pc_inc     <= 1'b0;
      IR_out     <= '0;
      ir_valid   <= 1'b0;
      fetch_busy <= 1'b0;
      FAULT      <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      state      <= state_n;
      imem_req   <= req_n;
      imem_addr  <= addr_n;
      pc_inc     <= inc_n;
      IR_out     <= ir_n;
      ir_valid   <= vld_n;
      fetch_busy <= (state_n == WAIT);
      FAULT      <= fault_n;
      fault_code <= code_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small PC register model driven by pc_inc.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] PC_in;
  logic        fetch_start = 1'b0, flush = 1'b0, fault_clr = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic        pc_inc, ir_valid, ir_ready = 1'b0, fetch_busy, FAULT;
  logic [31:0] IR_out;
  logic [1:0]  fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pc_reg;
  logic        pc_set_en = 1'b0;
  logic [31:0] pc_set_val = 32'h0;

  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RESET) begin
    if (RESET)          pc_reg <= 32'h0;
    else if (pc_set_en) pc_reg <= pc_set_val;
    else if (pc_inc)    pc_reg <= pc_reg + 32'd4;
  end
  assign PC_in = pc_reg;

  instr_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .PC_in(PC_in), .fetch_start(fetch_start),
    .flush(flush), .fault_clr(fault_clr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_inc(pc_inc), .IR_out(IR_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .fetch_busy(fetch_busy), .FAULT(FAULT), .fault_code(fault_code)
  );

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_set_val = v; pc_set_en = 1'b1;
    tick();
    pc_set_en = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_checks++; if ({imem_req, pc_inc, ir_valid, fetch_busy, FAULT, fault_code} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000000", {imem_req, pc_inc, ir_valid, fetch_busy, FAULT, fault_code}); end
    n_checks++; if ({imem_addr, IR_out} !== 64'h0) begin
      n_fail++; $display("FAIL reset_regs: addr %h ir %h want 0", imem_addr, IR_out); end
    tick(); tick();
    RESET = 1'b0;
  endtask

  task automatic test_basic_fetch;
    set_pc(32'h40);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    n_checks++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", fetch_busy); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
        n_fail++; $display("FAIL basic_req_hold[%0d]: req %b addr %h want 1 00000040", i, imem_req, imem_addr); end
      if (i == 2) begin imem_ack = 1'b1; imem_rdata = 32'h2108_0004; end
      tick();
    end
    imem_ack = 1'b0;
    n_checks++; if ({IR_out, ir_valid, pc_inc, imem_req} !== {32'h2108_0004, 3'b110}) begin
      n_fail++; $display("FAIL basic_ir: ir %h vld %b inc %b req %b want 21080004 1 1 0", IR_out, ir_valid, pc_inc, imem_req); end
    tick();
    n_checks++; if ({pc_inc, pc_reg} !== {1'b0, 32'h44}) begin
      n_fail++; $display("FAIL basic_pc: inc %b pc %h want 0 00000044", pc_inc, pc_reg); end
    n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hold: vld %b want 1", ir_valid); end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume: vld %b want 0", ir_valid); end
  endtask

  task automatic test_back_to_back;
    set_pc(32'h40);
    fetch_start = 1'b1; ir_ready = 1'b1;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
    tick();
    imem_ack = 1'b0;
    n_checks++; if ({pc_inc, ir_valid, IR_out} !== {2'b11, 32'hAAAA_0001}) begin
      n_fail++; $display("FAIL b2b_first: inc %b vld %b ir %h want 1 1 aaaa0001", pc_inc, ir_valid, IR_out); end
    tick();
    n_checks++; if ({imem_req, ir_valid, fetch_busy, pc_inc} !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_no_launch_in_inc: req %b vld %b busy %b inc %b want 0000", imem_req, ir_valid, fetch_busy, pc_inc); end
    tick();
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h44}) begin
      n_fail++; $display("FAIL b2b_second_addr: req %b addr %h want 1 00000044", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hBBBB_0002;
    tick();
    imem_ack = 1'b0; fetch_start = 1'b0; ir_ready = 1'b0;
    n_checks++; if ({pc_inc, ir_valid, IR_out} !== {2'b11, 32'hBBBB_0002}) begin
      n_fail++; $display("FAIL b2b_second_ir: inc %b vld %b ir %h want 1 1 bbbb0002", pc_inc, ir_valid, IR_out); end
    tick();
    n_checks++; if ({ir_valid, pc_inc, pc_reg} !== {2'b10, 32'h48}) begin
      n_fail++; $display("FAIL b2b_hold: vld %b inc %b pc %h want 1 0 00000048", ir_valid, pc_inc, pc_reg); end
    fetch_start = 1'b1; ir_ready = 1'b1;
    tick();
    n_checks++; if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h48, 1'b0}) begin
      n_fail++; $display("FAIL b2b_hold_launch: req %b addr %h vld %b want 1 00000048 0", imem_req, imem_addr, ir_valid); end
    fetch_start = 1'b0; ir_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hCCCC_0003;
    tick();
    imem_ack = 1'b0; ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    n_checks++; if ({IR_out, ir_valid, pc_reg} !== {32'hCCCC_0003, 1'b0, 32'h4C}) begin
      n_fail++; $display("FAIL b2b_third: ir %h vld %b pc %h want cccc0003 0 0000004c", IR_out, ir_valid, pc_reg); end
  endtask

  task automatic test_misalign;
    set_pc(32'h42);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    n_checks++; if ({FAULT, fault_code, imem_req, fetch_busy} !== 5'b10100) begin
      n_fail++; $display("FAIL misalign_fault: got %b want 10100", {FAULT, fault_code, imem_req, fetch_busy}); end
    tick();
    n_checks++; if ({imem_req, FAULT} !== 2'b01) begin
      n_fail++; $display("FAIL misalign_sticky: req %b fault %b want 0 1", imem_req, FAULT); end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    n_checks++; if ({FAULT, fault_code} !== 3'b000) begin
      n_fail++; $display("FAIL misalign_clr: got %b want 000", {FAULT, fault_code}); end
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    int inc_seen = 0;
    set_pc(32'h100);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pc_inc) inc_seen++;
      if (!imem_req) break;
      req_cycles++;
      tick();
    end
    n_checks++; if (req_cycles !== 16) begin n_fail++; $display("FAIL timeout_len: req cycles %0d want 16", req_cycles); end
    n_checks++; if ({FAULT, fault_code, fetch_busy} !== 4'b1100) begin
      n_fail++; $display("FAIL timeout_fault: got %b want 1100", {FAULT, fault_code, fetch_busy}); end
    n_checks++; if (inc_seen !== 0 || pc_reg !== 32'h100) begin
      n_fail++; $display("FAIL timeout_no_inc: inc %0d pc %h want 0 00000100", inc_seen, pc_reg); end
  endtask

  task automatic test_fault_priority;
    set_pc(32'h43);
    fault_clr = 1'b1; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    n_checks++; if ({FAULT, fault_code} !== 3'b101) begin
      n_fail++; $display("FAIL fault_new_wins: got %b want 101", {FAULT, fault_code}); end
    tick();
    fault_clr = 1'b0;
    n_checks++; if ({FAULT, fault_code} !== 3'b000) begin
      n_fail++; $display("FAIL fault_clr2: got %b want 000", {FAULT, fault_code}); end
  endtask

  task automatic test_ack_at_timeout;
    set_pc(32'h300);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL edge_req: got %b want 1", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_ack = 1'b0;
    n_checks++; if ({IR_out, ir_valid, pc_inc, FAULT} !== {32'hCAFE_F00D, 3'b110}) begin
      n_fail++; $display("FAIL edge_ack_wins: ir %h vld %b inc %b fault %b want cafef00d 1 1 0", IR_out, ir_valid, pc_inc, FAULT); end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
  endtask

  task automatic test_ack_outside_wait;
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    n_checks++; if ({IR_out, ir_valid, pc_inc} !== {32'hCAFE_F00D, 2'b00}) begin
      n_fail++; $display("FAIL stray_ack: ir %h vld %b inc %b want cafef00d 0 0", IR_out, ir_valid, pc_inc); end
  endtask

  task automatic test_flush_ack;
    set_pc(32'h200);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    flush = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0; imem_ack = 1'b0;
    n_checks++; if ({IR_out, ir_valid, pc_inc, imem_req, fetch_busy} !== {32'hCAFE_F00D, 4'b0000}) begin
      n_fail++; $display("FAIL flush_ack: ir %h vld %b inc %b req %b busy %b want cafef00d 0000", IR_out, ir_valid, pc_inc, imem_req, fetch_busy); end
    tick();
    n_checks++; if ({pc_inc, pc_reg, FAULT} !== {1'b0, 32'h200, 1'b0}) begin
      n_fail++; $display("FAIL flush_pc: inc %b pc %h fault %b want 0 00000200 0", pc_inc, pc_reg, FAULT); end
  endtask

  task automatic test_async_reset;
    set_pc(32'h80);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL areset_pre_req: got %b want 1", imem_req); end
    #2 RESET = 1'b1;
    #1;
    n_checks++; if ({imem_req, pc_inc, ir_valid, fetch_busy, FAULT, fault_code, imem_addr, IR_out} !== 71'h0) begin
      n_fail++; $display("FAIL areset_outputs: req %b addr %h ir %h vld %b busy %b", imem_req, imem_addr, IR_out, ir_valid, fetch_busy); end
    tick();
    RESET = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_fault_priority();
    test_ack_at_timeout();
    test_ack_outside_wait();
    test_flush_ack();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the 32-bit program counter register in the multicycle CPU.
- On request from the control unit, it takes the current PC and issues a word read to instruction memory over a req/ack handshake.
- It latches the returned word into the instruction register (IR) and pulses pc_inc so the PC advances by 4.
- It holds the IR valid until decode accepts it, and detects misaligned-PC and memory-timeout faults.

Parameters:
- DATA_W, 32, instruction/address width.
- TIMEOUT, 16, maximum WAIT cycles without imem_ack before a timeout fault (≥2).
- TO_W, clog2(TIMEOUT), timeout counter width (derived, not overridable).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PC_in  in  32  current PC value from the PC register output.
- fetch_start  in  1  level request from control unit to fetch at PC_in.
- flush  in  1  synchronous abort; highest priority after RESET.
- fault_clr  in  1  clears sticky FAULT/fault_code.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address; stable while imem_req=1.
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- pc_inc  out  1  one-cycle pulse to the PC increment input.
- IR_out  out  32  instruction register.
- ir_valid  out  1  IR_out holds an unconsumed instruction.
- ir_ready  in  1  decode consumes IR_out when ir_valid=1.
- fetch_busy  out  1  state is WAIT.
- FAULT  out  1  sticky fault flag.
- fault_code  out  2  01 = misaligned PC, 10 = timeout, 00 = none.

Behaviour:
- Reset (asynchronous): state IDLE; imem_req=0, imem_addr=0, pc_inc=0, IR_out=0, ir_valid=0, fetch_busy=0, FAULT=0, fault_code=00, timeout counter=0.
- States: IDLE, WAIT, HOLD. All outputs are registered.
- Launch condition:
  - fetch_start=1 and flush=0, in IDLE, or in HOLD with ir_ready=1 and pc_inc=0.
  - At that edge, if PC_in[1:0]≠00: FAULT<=1, fault_code<=01, no request issued, state IDLE (ir_valid cleared if leaving HOLD).
  - Otherwise: imem_addr<=PC_in, imem_req<=1, counter<=0, state WAIT; if leaving HOLD, ir_valid<=0 in the same edge.
- HOLD with pc_inc=1 (first HOLD cycle): a launch is not taken, because PC_in has not yet advanced. ir_ready is still honoured; if ir_ready=1 and fetch_start=1 in that cycle, the block goes to IDLE and launches on the next edge if fetch_start is still high.
- WAIT:
  - imem_req and imem_addr are held until imem_ack.
  - On imem_ack=1: IR_out<=imem_rdata, ir_valid<=1, imem_req<=0, pc_inc<=1, state HOLD. Latency: IR valid 1 edge after ack; minimum 2 cycles from launch to ir_valid.
  - Otherwise counter++. When counter reaches TIMEOUT-1 with no ack: imem_req<=0, FAULT<=1, fault_code<=10, state IDLE, no pc_inc.
  - Ack on the same edge as timeout: the ack wins and the fetch completes normally.
- pc_inc: high for exactly one cycle, the first cycle of HOLD. It is never asserted on fault or flush paths.
- HOLD without launch:
  - ir_ready=1 → ir_valid<=0, state IDLE.
  - ir_ready=0 → IR_out and ir_valid are held indefinitely.
- flush=1 (any state):
  - Next edge: imem_req=0, ir_valid=0, state IDLE, counter=0.
  - An imem_ack arriving in the same cycle is discarded: IR_out unchanged, no pc_inc.
  - A pc_inc already high in that cycle is not retracted.
  - IR_out keeps its last value; FAULT is unaffected.
- fault_clr: FAULT<=0, fault_code<=00. A new fault detected at the same edge wins.
- A second fault while FAULT=1 overwrites fault_code with the newest cause.
- imem_ack outside WAIT is ignored.

Decomposition:
- Shared package cpu_defs:
  - fetch state encoding (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2);
  - fault codes (FLT_NONE, FLT_MISALIGN, FLT_TIMEOUT);
  - DATA_W default.
- One natural sub-module, fetch_timeout_ctr: TO_W counter with clear/enable inputs and an expired output.

Test Plan:
- RESET mid-WAIT (imem_req=1): all outputs return to reset values asynchronously, without waiting for a clock edge.
- PC_in=0x0000_0040, fetch_start=1, imem_ack after 3 WAIT cycles with rdata=0x2108_0004:
  - imem_addr=0x40 held throughout;
  - IR_out=0x2108_0004, ir_valid=1;
  - single pc_inc pulse, so the PC register reads 0x44.
- ir_ready=1 and fetch_start=1 held in HOLD: no launch in the pc_inc cycle; the next launch has imem_addr=0x44; no ack is ever lost.
- PC_in=0x0000_0042, fetch_start=1: FAULT=1, fault_code=01, imem_req never rises; after fault_clr, FAULT=0.
- No ack for TIMEOUT=16 cycles: imem_req drops at cycle 16, fault_code=10, pc_inc stays 0.
- flush asserted in the same cycle as imem_ack: IR_out unchanged, ir_valid=0, no pc_inc, state IDLE.
